// File: rtl/paicore_hs_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// paicore_hs_responder
//
// Loopback responder for a host that talks 4-phase request/acknowledge.
// Inbound words are accepted from the host transmitter, queued in a FIFO and
// replayed in order to the host receiver. Counters track accepted and
// completed words, and a sticky flag reports when the outbound count reaches
// a programmed frame length.
//
// Handshake semantics (both sides):
//   request rises with data stable -> acknowledge rises -> request falls ->
//   acknowledge falls. Exactly one word moves per request/acknowledge cycle.
//   A request still high while acknowledge is high never moves a second word.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   i_rx_request        inbound request; i_rx_din valid while high
//   i_rx_din            inbound data word
//   o_rx_acknowledge    inbound acknowledge
//   o_tx_request        outbound request
//   o_tx_dout           outbound data word, stable while o_tx_request is high
//   i_tx_acknowledge    outbound acknowledge from the host receiver
//   i_clear             synchronous clear of counters and o_tx_done
//   i_frame_num         outbound word count that sets o_tx_done (0 = never)
//   o_rx_cnt, o_tx_cnt  accepted / completed word counters (wrap at 2^32)
//   o_fifo_level        words held, including the one being offered outbound
//   o_tx_done           sticky: o_tx_cnt reached i_frame_num
//   o_dbg_rx_state      receive FSM state (0 = RX_IDLE, 1 = RX_ACK)
//   o_dbg_tx_state      transmit FSM state (0 = TX_IDLE, 1 = TX_REQ, 2 = TX_WAIT)
// -----------------------------------------------------------------------------
module paicore_hs_responder #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_request,
  input  logic [DATA_W-1:0] i_rx_din,
  output logic              o_rx_acknowledge,
  output logic              o_tx_request,
  output logic [DATA_W-1:0] o_tx_dout,
  input  logic              i_tx_acknowledge,
  input  logic              i_clear,
  input  logic [31:0]       i_frame_num,
  output logic [31:0]       o_rx_cnt,
  output logic [31:0]       o_tx_cnt,
  output logic [LW-1:0]     o_fifo_level,
  output logic              o_tx_done,
  output logic [0:0]        o_dbg_rx_state,
  output logic [1:0]        o_dbg_tx_state
);

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  logic              push;     // inbound word accepted this cycle
  logic              load;     // head word copied to the outbound register
  logic              retire;   // outbound word acknowledged, head slot freed
  logic [DATA_W-1:0] tx_dout_q;
  logic [31:0]       rx_cnt_q, tx_cnt_q;
  logic              tx_done_q;
  logic [31:0]       tx_cnt_inc;

  assign fifo_full  = (fifo_count == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        // Full FIFO holds the request off with acknowledge low.
        if (i_rx_request && !fifo_full) begin
          push    = 1'b1;
          rx_next = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!i_rx_request) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Decoded from the state register so reset drops it without a clock.
  assign o_rx_acknowledge = (rx_state == RX_ACK);

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // The head word is copied to the output register on entry to TX_REQ, but its
  // FIFO slot is only released when the host acknowledges. The in-flight word
  // therefore still counts toward o_fifo_level, and a reset discards it along
  // with the rest of the FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    load    = 1'b0;
    retire  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          tx_next = TX_REQ;
        end
      end
      TX_REQ: begin
        if (i_tx_acknowledge) begin
          retire  = 1'b1;
          tx_next = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!i_tx_acknowledge) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  assign o_tx_request = (tx_state == TX_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tx_dout_q <= '0;
    else if (load) tx_dout_q <= mem[rd_ptr];
  end

  assign o_tx_dout = tx_dout_q;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers. Depth is a power of two, so the pointers wrap
  // by natural overflow.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_rx_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (retire) rd_ptr <= rd_ptr + AW'(1);
      case ({push, retire})
        2'b10:   fifo_count <= fifo_count + LW'(1);
        2'b01:   fifo_count <= fifo_count - LW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign o_fifo_level = fifo_count;

  // ---------------------------------------------------------------------------
  // Counters and done flag; i_clear takes priority over any increment.
  // ---------------------------------------------------------------------------
  assign tx_cnt_inc = tx_cnt_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      tx_done_q <= 1'b0;
    end else if (i_clear) begin
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      if (push)   rx_cnt_q <= rx_cnt_q + 32'd1;
      if (retire) begin
        tx_cnt_q <= tx_cnt_inc;
        if ((i_frame_num != 32'd0) && (tx_cnt_inc == i_frame_num))
          tx_done_q <= 1'b1;
      end
    end
  end

  assign o_rx_cnt  = rx_cnt_q;
  assign o_tx_cnt  = tx_cnt_q;
  assign o_tx_done = tx_done_q;

  assign o_dbg_rx_state = rx_state;
  assign o_dbg_tx_state = tx_state;

endmodule

// File: tb/tb_paicore_hs_responder.sv
`timescale 1ns/1ps
// Testbench for paicore_hs_responder: directed handshake sequences with a
// scoreboard queue for outbound data order.
module tb_paicore_hs_responder;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic              i_rx_request;
  logic [DATA_W-1:0] i_rx_din;
  logic              o_rx_acknowledge;
  logic              o_tx_request;
  logic [DATA_W-1:0] o_tx_dout;
  logic              i_tx_acknowledge;
  logic              i_clear;
  logic [31:0]       i_frame_num;
  logic [31:0]       o_rx_cnt;
  logic [31:0]       o_tx_cnt;
  logic [LW-1:0]     o_fifo_level;
  logic              o_tx_done;
  logic [0:0]        o_dbg_rx_state;
  logic [1:0]        o_dbg_tx_state;

  always #5 clk = ~clk;

  paicore_hs_responder #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rx_request     (i_rx_request),
    .i_rx_din         (i_rx_din),
    .o_rx_acknowledge (o_rx_acknowledge),
    .o_tx_request     (o_tx_request),
    .o_tx_dout        (o_tx_dout),
    .i_tx_acknowledge (i_tx_acknowledge),
    .i_clear          (i_clear),
    .i_frame_num      (i_frame_num),
    .o_rx_cnt         (o_rx_cnt),
    .o_tx_cnt         (o_tx_cnt),
    .o_fifo_level     (o_fifo_level),
    .o_tx_done        (o_tx_done),
    .o_dbg_rx_state   (o_dbg_rx_state),
    .o_dbg_tx_state   (o_dbg_tx_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  // Full inbound 4-phase handshake.
  task automatic host_send(input logic [31:0] d, input string tag);
    int n;
    i_rx_din     = d;
    i_rx_request = 1'b1;
    n = 0;
    do begin tick(); n++; end while (o_rx_acknowledge !== 1'b1 && n < 400);
    check({tag, "_ack_rise"}, {31'd0, o_rx_acknowledge}, 32'd1);
    i_rx_request = 1'b0;
    n = 0;
    do begin tick(); n++; end while (o_rx_acknowledge !== 1'b0 && n < 50);
    check({tag, "_ack_fall"}, {31'd0, o_rx_acknowledge}, 32'd0);
  endtask

  // Receive nwords outbound words, acknowledging after 0..max_dly cycles.
  task automatic host_recv(input int nwords, input int max_dly, input string tag);
    int n;
    for (int i = 0; i < nwords; i++) begin
      n = 0;
      while (o_tx_request !== 1'b1 && n < 400) begin tick(); n++; end
      check({tag, "_req_rise"}, {31'd0, o_tx_request}, 32'd1);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else                   check({tag, "_data"}, o_tx_dout, exp_q.pop_front());
      repeat ($urandom_range(max_dly, 0)) tick();
      i_tx_acknowledge = 1'b1;
      n = 0;
      do begin tick(); n++; end while (o_tx_request !== 1'b0 && n < 50);
      check({tag, "_req_fall"}, {31'd0, o_tx_request}, 32'd0);
      i_tx_acknowledge = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] word;

    rst              = 1'b1;
    i_rx_request     = 1'b0;
    i_rx_din         = '0;
    i_tx_acknowledge = 1'b0;
    i_clear          = 1'b0;
    i_frame_num      = 32'd0;
    repeat (3) tick();

    // Reset state
    check("rst_rx_ack",   {31'd0, o_rx_acknowledge}, 32'd0);
    check("rst_tx_req",   {31'd0, o_tx_request}, 32'd0);
    check("rst_tx_dout",  o_tx_dout, 32'd0);
    check("rst_rx_cnt",   o_rx_cnt, 32'd0);
    check("rst_tx_cnt",   o_tx_cnt, 32'd0);
    check("rst_level",    32'(o_fifo_level), 32'd0);
    check("rst_done",     {31'd0, o_tx_done}, 32'd0);
    check("rst_rx_state", 32'(o_dbg_rx_state), 32'd0);
    check("rst_tx_state", 32'(o_dbg_tx_state), 32'd0);
    rst = 1'b0;
    tick();

    // Single word, cycle-exact
    i_rx_din     = 32'hDEADBEEF;
    i_rx_request = 1'b1;
    tick();
    check("one_ack_next_cycle", {31'd0, o_rx_acknowledge}, 32'd1);
    check("one_no_early_req",   {31'd0, o_tx_request}, 32'd0);
    check("one_level",          32'(o_fifo_level), 32'd1);
    check("one_rx_cnt",         o_rx_cnt, 32'd1);
    i_rx_request = 1'b0;
    tick();
    check("one_ack_drop",  {31'd0, o_rx_acknowledge}, 32'd0);
    check("one_tx_req",    {31'd0, o_tx_request}, 32'd1);
    check("one_tx_dout",   o_tx_dout, 32'hDEADBEEF);
    i_tx_acknowledge = 1'b1;
    tick();
    check("one_tx_req_drop", {31'd0, o_tx_request}, 32'd0);
    check("one_rx_cnt_fin",  o_rx_cnt, 32'd1);
    check("one_tx_cnt_fin",  o_tx_cnt, 32'd1);
    check("one_level_fin",   32'(o_fifo_level), 32'd0);
    i_tx_acknowledge = 1'b0;
    tick();

    // Burst of 40 words with random receiver latency, done flag at 40
    pulse_clear();
    check("clr_rx_cnt", o_rx_cnt, 32'd0);
    check("clr_tx_cnt", o_tx_cnt, 32'd0);
    i_frame_num = 32'd40;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          exp_q.push_back(32'(i));
          host_send(32'(i), "burst");
        end
      end
      begin
        host_recv(40, 5, "burst");
      end
    join
    check("burst_rx_cnt", o_rx_cnt, 32'd40);
    check("burst_tx_cnt", o_tx_cnt, 32'd40);
    check("burst_done",   {31'd0, o_tx_done}, 32'd1);
    check("burst_sb_left", 32'(exp_q.size()), 32'd0);
    tick();
    check("burst_done_sticky", {31'd0, o_tx_done}, 32'd1);
    i_frame_num = 32'd0;
    pulse_clear();
    check("clr_done", {31'd0, o_tx_done}, 32'd0);

    // Full FIFO backpressure
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h100 + 32'(i));
      host_send(32'h100 + 32'(i), "fill");
    end
    check("full_level",  32'(o_fifo_level), 32'd16);
    check("full_tx_req", {31'd0, o_tx_request}, 32'd1);
    check("full_head",   o_tx_dout, exp_q.pop_front());
    exp_q.push_back(32'h110);
    i_rx_din     = 32'h110;
    i_rx_request = 1'b1;
    repeat (3) tick();
    check("full_17_no_ack", {31'd0, o_rx_acknowledge}, 32'd0);
    check("full_17_level",  32'(o_fifo_level), 32'd16);
    check("full_17_rx_cnt", o_rx_cnt, 32'd16);
    i_tx_acknowledge = 1'b1;
    tick();
    check("full_retire_req",   {31'd0, o_tx_request}, 32'd0);
    check("full_retire_level", 32'(o_fifo_level), 32'd15);
    check("full_retire_cnt",   o_tx_cnt, 32'd1);
    i_tx_acknowledge = 1'b0;
    tick();
    check("full_17_ack",       {31'd0, o_rx_acknowledge}, 32'd1);
    check("full_17_level_back", 32'(o_fifo_level), 32'd16);
    i_rx_request = 1'b0;
    tick();
    check("full_17_ack_drop", {31'd0, o_rx_acknowledge}, 32'd0);
    host_recv(16, 2, "drain");
    check("drain_level",  32'(o_fifo_level), 32'd0);
    check("drain_rx_cnt", o_rx_cnt, 32'd17);
    check("drain_tx_cnt", o_tx_cnt, 32'd17);

    // Push and retire in the same cycle, with i_clear on the same edge
    word = 32'hA5A50001;
    host_send(word, "simA");
    check("sim_pre_req",   {31'd0, o_tx_request}, 32'd1);
    check("sim_pre_dout",  o_tx_dout, word);
    check("sim_pre_level", 32'(o_fifo_level), 32'd1);
    i_rx_din         = 32'hA5A50002;
    i_rx_request     = 1'b1;
    i_tx_acknowledge = 1'b1;
    i_clear          = 1'b1;
    tick();
    check("sim_level_const", 32'(o_fifo_level), 32'd1);
    check("sim_rx_ack",      {31'd0, o_rx_acknowledge}, 32'd1);
    check("sim_tx_req_drop", {31'd0, o_tx_request}, 32'd0);
    check("sim_clr_tx_cnt",  o_tx_cnt, 32'd0);
    check("sim_clr_rx_cnt",  o_rx_cnt, 32'd0);
    i_rx_request     = 1'b0;
    i_tx_acknowledge = 1'b0;
    i_clear          = 1'b0;
    tick();
    check("sim_ack_drop", {31'd0, o_rx_acknowledge}, 32'd0);
    exp_q.push_back(32'hA5A50002);
    host_recv(1, 0, "simB");
    check("sim_post_tx_cnt", o_tx_cnt, 32'd1);
    check("sim_post_rx_cnt", o_rx_cnt, 32'd0);

    // Reset in the middle of both handshakes
    host_send(32'hC0C0C0C0, "rstC");
    i_rx_din     = 32'hD0D0D0D0;
    i_rx_request = 1'b1;
    tick();
    check("mid_pre_ack", {31'd0, o_rx_acknowledge}, 32'd1);
    check("mid_pre_req", {31'd0, o_tx_request}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rx_ack", {31'd0, o_rx_acknowledge}, 32'd0);
    check("mid_tx_req", {31'd0, o_tx_request}, 32'd0);
    check("mid_dout",   o_tx_dout, 32'd0);
    check("mid_level",  32'(o_fifo_level), 32'd0);
    check("mid_rx_cnt", o_rx_cnt, 32'd0);
    check("mid_tx_cnt", o_tx_cnt, 32'd0);
    check("mid_done",   {31'd0, o_tx_done}, 32'd0);
    i_rx_request = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(32'h12345678);
    host_send(32'h12345678, "post");
    host_recv(1, 1, "post");
    check("post_rx_cnt", o_rx_cnt, 32'd1);
    check("post_tx_cnt", o_tx_cnt, 32'd1);
    check("post_level",  32'(o_fifo_level), 32'd0);
    check("post_sb_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paicore_hs_responder.md
PAICORE_HS_RESPONDER -- requirements
Module: paicore_hs_responder

Interface
REQ-001 Parameter DATA_W, default 32, width of the handshake data words on both sides.
REQ-002 Parameter FIFO_DEPTH, default 16, number of words in the loopback FIFO; power of two and at least 2.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port i_rx_request  input  1  inbound request from the host transmitter; i_rx_din is valid while it is high.
REQ-006 Port i_rx_din  input  DATA_W  inbound data word.
REQ-007 Port o_rx_acknowledge  output  1  inbound acknowledge to the host transmitter.
REQ-008 Port o_tx_request  output  1  outbound request to the host receiver.
REQ-009 Port o_tx_dout  output  DATA_W  outbound data word.
REQ-010 Port i_tx_acknowledge  input  1  outbound acknowledge from the host receiver.
REQ-011 Port i_clear  input  1  synchronous clear of the counters and o_tx_done.
REQ-012 Port i_frame_num  input  32  expected number of outbound words for done detection.
REQ-013 Port o_rx_cnt  output  32  count of accepted inbound words.
REQ-014 Port o_tx_cnt  output  32  count of completed outbound words.
REQ-015 Port o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 Port o_tx_done  output  1  sticky flag: o_tx_cnt has reached i_frame_num.

Function
REQ-017 Both sides shall use a 4-phase handshake: request rises with data stable, acknowledge rises, request falls, acknowledge falls.
REQ-018 All inputs are synchronous to clk; no synchronizers shall be inserted.
REQ-019 The receive FSM shall have two states, RX_IDLE and RX_ACK.
REQ-020 In RX_IDLE, when i_rx_request=1 and the FIFO is not full, the block shall write i_rx_din into the FIFO, increment o_rx_cnt, and enter RX_ACK; o_rx_acknowledge goes to 1 on the next cycle.
REQ-021 In RX_IDLE with i_rx_request=1 and the FIFO full, the block shall not write and shall keep o_rx_acknowledge=0 until space frees (backpressure).
REQ-022 In RX_ACK, o_rx_acknowledge shall stay 1 until i_rx_request is sampled 0; it then returns to 0 and the FSM goes to RX_IDLE.
REQ-023 A request still high while acknowledge is high shall never cause a second write; exactly one word is written per handshake.
REQ-024 The transmit FSM shall have three states: TX_IDLE, TX_REQ and TX_WAIT.
REQ-025 In TX_IDLE with the FIFO not empty, the block shall pop the head word into o_tx_dout and set o_tx_request=1 on the next cycle (TX_REQ).
REQ-026 In TX_REQ, o_tx_dout shall be held stable; when i_tx_acknowledge=1 is sampled, o_tx_request shall go to 0, o_tx_cnt shall increment, and the FSM shall enter TX_WAIT.
REQ-027 In TX_WAIT, the FSM shall return to TX_IDLE when i_tx_acknowledge=0 is sampled.
REQ-028 A FIFO write and pop in the same cycle shall leave o_fifo_level unchanged.
REQ-029 The FIFO pointers shall wrap modulo FIFO_DEPTH, and the data order shall be preserved.
REQ-030 Minimum round trip: a word accepted at cycle N shall drive o_tx_request=1 at cycle N+2 at the earliest.
REQ-031 o_rx_cnt and o_tx_cnt shall wrap from 2^32-1 to 0.
REQ-032 o_tx_done shall set on the cycle o_tx_cnt becomes equal to i_frame_num (i_frame_num != 0) and hold until i_clear or rst.
REQ-033 i_clear shall zero o_rx_cnt, o_tx_cnt and o_tx_done.
REQ-034 i_clear shall not affect the FIFO or either FSM.
REQ-035 If an increment and i_clear occur together, i_clear shall win.

Reset
REQ-036 While rst=1, the following outputs shall be 0: o_rx_acknowledge, o_tx_request, o_tx_dout, o_rx_cnt, o_tx_cnt, o_fifo_level, o_tx_done.
REQ-037 While rst=1, both FSMs shall be in their IDLE states and the FIFO pointers shall be 0.
REQ-038 Reset asserted mid-handshake shall drop acknowledge and request immediately (asynchronously), discard FIFO contents, and discard any in-flight word.

Verification
REQ-039 Single word: drive 0xDEADBEEF with an inbound handshake.
- o_rx_acknowledge=1 one cycle after request.
- The word appears on o_tx_dout with o_tx_request=1; after the external acknowledge, o_rx_cnt=o_tx_cnt=1.
REQ-040 Burst order: send 40 words (0..39) with i_tx_acknowledge responding after a random 0-5 cycle delay.
- Output is identical and in order.
- o_tx_done=1 when i_frame_num=40.
REQ-041 Full FIFO: hold i_tx_acknowledge=0 and send 17 words with FIFO_DEPTH=16.
- o_fifo_level=16 and the 17th request stays unacknowledged.
- After one outbound handshake completes, the 17th is acknowledged and the level returns to 16.
REQ-042 Simultaneous events:
- A push and a pop in the same cycle keep the level constant.
- i_clear together with an o_tx_cnt increment leaves o_tx_cnt=0.
REQ-043 Reset mid-handshake: assert rst while o_rx_acknowledge=1 and o_tx_request=1.
- All outputs go to 0 without a clock edge.
- After release, a new word passes through normally with counts of 1.
